// File: rtl/key_event_queue.sv
// Key-press event extractor with code filter and show-ahead FIFO.
// Converts level-style PS/2 ASCII/released signals into queued press events.
module key_event_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [7:0]  ACCEPT_LO = 8'h20,
  parameter logic [7:0]  ACCEPT_HI = 8'h7e
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [7:0]                 rx_ascii,
  input  logic                       rx_released,
  input  logic                       en,
  input  logic                       clear,
  input  logic                       key_ready,
  output logic                       key_valid,
  output logic [7:0]                 key_ascii,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic             prev_released;
  logic [7:0]       prev_ascii;
  logic [7:0]       storage [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  logic press, accepted, push, pop, full, do_write;

  always_comb begin
    press    = !rx_released && (prev_released || (rx_ascii != prev_ascii));
    accepted = ((rx_ascii >= ACCEPT_LO) && (rx_ascii <= ACCEPT_HI)) ||
               (rx_ascii == 8'h08) || (rx_ascii == 8'h0d) || (rx_ascii == 8'h1b);
    push     = press && accepted && en && !clear;
    pop      = key_valid && key_ready && !clear;
    full     = (count == CNT_W'(DEPTH));
    // A full queue still accepts a push when the head leaves on the same edge.
    do_write = push && (!full || pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_released <= 1'b1;
      prev_ascii    <= 8'h00;
    end else begin
      prev_released <= rx_released;
      prev_ascii    <= rx_ascii;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (pop)      rd_ptr <= rd_ptr + 1'b1;
      if (do_write && !pop)      count <= count + 1'b1;
      else if (!do_write && pop) count <= count - 1'b1;
      if (push && full && !pop)  overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) storage[wr_ptr] <= rx_ascii;
  end

  always_comb begin
    key_valid = (count != '0);
    key_ascii = key_valid ? storage[rd_ptr] : 8'h00;
  end

endmodule

// File: tb/tb_key_event_queue.sv
// Directed bench for key_event_queue: edge detect, filter, FIFO order, overflow, clear, reset.
module tb_key_event_queue;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_ascii;
  logic       rx_released;
  logic       en;
  logic       clear;
  logic       key_ready;
  logic       key_valid;
  logic [7:0] key_ascii;
  logic [2:0] count;
  logic       overflow;

  int unsigned tests = 0;
  int unsigned fails = 0;

  key_event_queue #(.DEPTH(4), .ACCEPT_LO(8'h20), .ACCEPT_HI(8'h7e)) dut (
    .clk(clk), .reset(reset), .rx_ascii(rx_ascii), .rx_released(rx_released),
    .en(en), .clear(clear), .key_ready(key_ready), .key_valid(key_valid),
    .key_ascii(key_ascii), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks the full visible state: valid, head, count, overflow.
  task automatic chk_all(input string tag, input int v, input int a, input int c, input int o);
    chk({tag, "_valid"}, int'(key_valid), v);
    chk({tag, "_ascii"}, int'(key_ascii), a);
    chk({tag, "_count"}, int'(count), c);
    chk({tag, "_ovf"},   int'(overflow), o);
  endtask

  task automatic press(input logic [7:0] code);
    rx_released = 1'b0;
    rx_ascii    = code;
    tick();
  endtask

  task automatic release_key();
    rx_released = 1'b1;
    tick();
  endtask

  initial begin
    reset = 1'b1; rx_ascii = 8'h00; rx_released = 1'b1;
    en = 1'b1; clear = 1'b0; key_ready = 1'b0;
    tick(); tick();
    chk_all("reset", 0, 8'h00, 0, 0);
    reset = 1'b0;
    tick();
    chk_all("idle", 0, 8'h00, 0, 0);

    // Held key: one event only
    press(8'h61);
    chk_all("hold_first", 1, 8'h61, 1, 0);
    repeat (19) tick();
    chk_all("hold_20", 1, 8'h61, 1, 0);
    release_key();
    key_ready = 1'b1;
    tick();
    chk_all("hold_drain", 0, 8'h00, 0, 0);

    // Streaming a,b,c with ready high: push on empty is not popped
    press(8'h61);
    chk_all("seq_a", 1, 8'h61, 1, 0);
    press(8'h62);
    chk_all("seq_b", 1, 8'h62, 1, 0);
    press(8'h63);
    chk_all("seq_c", 1, 8'h63, 1, 0);
    tick();
    chk_all("seq_empty", 0, 8'h00, 0, 0);
    key_ready = 1'b0;
    release_key();

    // Overflow on full queue
    press(8'h41); press(8'h42); press(8'h43); press(8'h44);
    chk_all("full4", 1, 8'h41, 4, 0);
    press(8'h45);
    chk_all("ovf_drop", 1, 8'h41, 4, 1);
    key_ready = 1'b1;
    press(8'h46);
    chk_all("full_pushpop", 1, 8'h42, 4, 1);
    tick(); chk_all("drain_43", 1, 8'h43, 3, 1);
    tick(); chk_all("drain_44", 1, 8'h44, 2, 1);
    tick(); chk_all("drain_46", 1, 8'h46, 1, 1);
    tick(); chk_all("drain_end", 0, 8'h00, 0, 1);
    key_ready = 1'b0;
    clear = 1'b1;
    tick();
    chk_all("ovf_clear", 0, 8'h00, 0, 0);
    clear = 1'b0;
    release_key();

    // Code filter and enable
    press(8'h00); chk("filt_00", int'(count), 0);
    release_key();
    press(8'h09); chk("filt_09", int'(count), 0);
    release_key();
    press(8'h7f); chk("filt_7f", int'(count), 0);
    release_key();
    press(8'h1f); chk("filt_1f", int'(count), 0);
    release_key();
    press(8'h0d); chk_all("filt_0d", 1, 8'h0d, 1, 0);
    release_key();
    press(8'h7e); chk_all("filt_7e", 1, 8'h0d, 2, 0);
    release_key();
    en = 1'b0;
    press(8'h1b); chk("en_off", int'(count), 2);
    en = 1'b1;
    tick(); chk("en_reraise", int'(count), 2);
    release_key();
    key_ready = 1'b1;
    tick(); chk_all("filt_pop1", 1, 8'h7e, 1, 0);
    tick(); chk_all("filt_pop2", 0, 8'h00, 0, 0);
    key_ready = 1'b0;

    // clear with concurrent press
    press(8'h31); press(8'h32); press(8'h33);
    chk_all("pre_clear", 1, 8'h31, 3, 0);
    clear = 1'b1;
    press(8'h41);
    chk_all("clear", 0, 8'h00, 0, 0);
    clear = 1'b0;
    tick(); tick();
    chk_all("clear_no_redetect", 0, 8'h00, 0, 0);
    release_key();

    // Async reset mid-burst, key held through release
    press(8'h51); press(8'h52);
    chk_all("pre_reset", 1, 8'h51, 2, 0);
    #2 reset = 1'b1;
    #1;
    chk_all("async_reset", 0, 8'h00, 0, 0);
    tick(); tick();
    chk_all("in_reset", 0, 8'h00, 0, 0);
    reset = 1'b0;
    tick();
    chk_all("held_after_reset", 1, 8'h52, 1, 0);
    tick(); tick();
    chk_all("held_once", 1, 8'h52, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/key_event_queue.md
Name: key_event_queue

Overview:
- Upstream stage between the PS/2 keyboard interface and the typing game controller.
- Turns the level-style ASCII and released outputs into discrete key-press events.
- Suppresses typematic auto-repeat and filters out non-game codes.
- Buffers events in a small show-ahead FIFO, so a keystroke arriving while the controller is busy (line swap, mode change) is held rather than lost.

Parameters:
DEPTH, 4, FIFO entries; power of two, 2..16
ACCEPT_LO, 8'h20, lowest printable code accepted
ACCEPT_HI, 8'h7e, highest printable code accepted

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
rx_ascii  input  8  ASCII of the current key from the PS/2 interface (level)
rx_released  input  1  high while the last PS/2 event was a key release (level)
en  input  1  capture enable; low means detected events are discarded
clear  input  1  synchronous flush of the FIFO and overflow flag
key_ready  input  1  consumer pops the head entry this cycle
key_valid  output  1  FIFO non-empty; key_ascii is valid
key_ascii  output  8  head-of-queue ASCII code
count  output  $clog2(DEPTH+1)  number of queued entries
overflow  output  1  sticky: an event was dropped because the FIFO was full

Behaviour:
- Reset (async) values:
  - count=0, key_valid=0, key_ascii=8'h00, overflow=0.
  - prev_released=1, prev_ascii=8'h00.
  - FIFO read/write pointers=0.
- Edge detection is evaluated every clk on the sampled inputs:
  - press = !rx_released && (prev_released || rx_ascii != prev_ascii).
  - prev_released <= rx_released and prev_ascii <= rx_ascii every cycle, regardless of en, clear or the filter.
  - A held key repeating the same code with rx_released low produces exactly one event.
- Code filter: accepted = (ACCEPT_LO <= rx_ascii <= ACCEPT_HI) or rx_ascii in {8'h08, 8'h0d, 8'h1b}. 8'h00 and all other codes are never accepted.
- push = press && accepted && en && !clear.
- pop = key_valid && key_ready && !clear. key_ready while empty is ignored.
- Latency: an input change sampled at edge n writes the FIFO at edge n; key_valid and key_ascii reflect it from edge n onward (1 cycle). There is no combinational fall-through from the input to key_ascii.
- Show-ahead output: key_ascii = storage[rd_ptr] when non-empty, otherwise holds 8'h00. After a pop the next entry appears on the same edge.
- Full (count==DEPTH):
  - push without pop: the event is dropped, overflow <= 1, storage and count unchanged.
  - push with pop: both are performed, count stays DEPTH, no overflow.
- Empty with push and key_ready in the same cycle: the push is stored and no pop occurs (key_valid was 0).
- Simultaneous push and pop when non-empty: count unchanged, order preserved.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- clear:
  - At the next edge: count=0, pointers=0, overflow=0, key_valid=0.
  - A press sampled in the same cycle is discarded, but prev_* still update, so it is not re-detected afterwards.
- Once set, overflow stays 1 until clear or reset.
- A reset asserted mid-operation drops all queued entries immediately (async). With prev_released=1 after reset, a key still held down at reset release is reported once as a new press.

Test Plan:
- Reset, then rx_released=0, rx_ascii=8'h61 held 20 cycles with key_ready=0 -> exactly one entry; key_valid=1 and key_ascii=8'h61 one cycle after the first sample; count=1.
- Sequence 'a','b','c' via ascii changes with rx_released=0 throughout, key_ready=1 -> key_ascii pops 8'h61, 8'h62, 8'h63 in order; count returns to 0.
- DEPTH=4, key_ready=0, five distinct accepted presses -> count=4, overflow=1, queue holds the first four codes. A sixth press in the same cycle as key_ready=1 -> count stays 4, fifth-pushed code at the tail, overflow still 1.
- rx_ascii=8'h00 then 8'h09 then 8'h0d, with a release between each -> only 8'h0d is queued; en=0 during a press of 8'h1b -> not queued; re-raising en while that key is still held -> still not queued.
- Queue holding 3 entries, clear pulsed together with a new press of 8'h41 -> next cycle count=0, key_valid=0, overflow=0, and 8'h41 is never delivered.
- Async reset asserted mid-burst with 2 entries queued -> key_valid=0 and count=0 immediately. Key held through reset release -> one event delivered.
